// File: rtl/id_branch_unit_pkg.sv
// Shared constants and types for the ID-stage branch resolution unit.
package id_branch_unit_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bht_state_t;

   function automatic logic is_cond_f3(input logic [2:0] f3);
      return (f3 != 3'b010) && (f3 != 3'b011);
   endfunction

endpackage

// File: rtl/id_branch_unit_if.sv
// Bus between the ID stage / fetch unit and the branch resolution unit.
interface id_branch_unit_if #(
   parameter int XLEN   = 32,
   parameter int PERF_W = 32
);
   logic              i_stall;
   logic              i_flush;
   logic              i_valid;
   logic [XLEN-1:0]   i_pc;
   logic [31:0]       i_instr;
   logic [XLEN-1:0]   i_imm;
   logic [XLEN-1:0]   i_rs1_val;
   logic [XLEN-1:0]   i_rs2_val;
   logic              i_pred_taken;
   logic [XLEN-1:0]   i_pred_target;
   logic [XLEN-1:0]   i_if_pc;
   logic              o_if_pred_taken;
   logic              o_redirect_valid;
   logic [XLEN-1:0]   o_redirect_pc;
   logic              o_mispred;
   logic              o_btb_update;
   logic [XLEN-1:0]   o_btb_update_pc;
   logic [XLEN-1:0]   o_btb_update_target;
   logic              i_perf_clear;
   logic [PERF_W-1:0] o_perf_branches;
   logic [PERF_W-1:0] o_perf_mispreds;
   logic              o_busy;

   modport master (
      output i_stall, i_flush, i_valid, i_pc, i_instr,
      output i_imm, i_rs1_val, i_rs2_val,
      output i_pred_taken, i_pred_target, i_if_pc,
      output i_perf_clear,
      input  o_if_pred_taken, o_redirect_valid, o_redirect_pc,
      input  o_mispred, o_btb_update, o_btb_update_pc,
      input  o_btb_update_target,
      input  o_perf_branches, o_perf_mispreds, o_busy
   );

   modport slave (
      input  i_stall, i_flush, i_valid, i_pc, i_instr,
      input  i_imm, i_rs1_val, i_rs2_val,
      input  i_pred_taken, i_pred_target, i_if_pc,
      input  i_perf_clear,
      output o_if_pred_taken, o_redirect_valid, o_redirect_pc,
      output o_mispred, o_btb_update, o_btb_update_pc,
      output o_btb_update_target,
      output o_perf_branches, o_perf_mispreds, o_busy
   );

endinterface

// File: rtl/id_branch_unit_bht_table.sv
// Saturating-counter table: async read, sync read-modify-write port.
module bht_table #(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int IDX_W    = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic [IDX_W-1:0]    rd_addr,
   output logic [CTR_BITS-1:0] rd_data,
   input  logic                wr_en,
   input  logic                wr_init,
   input  logic                wr_taken,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [CTR_BITS-1:0] init_val
);

   logic [CTR_BITS-1:0] mem [ENTRIES];
   logic [CTR_BITS-1:0] cur;
   logic [CTR_BITS-1:0] nxt;

   assign rd_data = mem[rd_addr];

   // Write port applies the saturating step to the pre-edge value.
   always_comb begin
      cur = mem[wr_addr];
      nxt = cur;
      if (wr_init) begin
         nxt = init_val;
      end else if (wr_taken) begin
         if (cur != '1) nxt = cur + 1'b1;
      end else begin
         if (cur != '0) nxt = cur - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= nxt;
   end

endmodule

// File: rtl/id_branch_unit.sv
// ID-stage branch/jump resolution with counter-table direction predictor.
module id_branch_unit
   import id_branch_unit_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2,
   parameter int PERF_W      = 32
) (
   input  logic i_clk,
   input  logic i_reset,
   id_branch_unit_if.slave bus
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_WNT =
      CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            is_br;
   logic            is_jmp;
   logic            fire;
   logic            res_br;
   logic            res_jmp;
   logic            cond;
   logic            taken;
   logic            mp;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] rd_pc;

   bht_state_t        state;
   logic [IDX_W-1:0]  init_idx;
   logic              busy;
   logic [PERF_W-1:0] perf_br;
   logic [PERF_W-1:0] perf_mp;

   logic [IDX_W-1:0]    rd_idx;
   logic [IDX_W-1:0]    wr_idx;
   logic [CTR_BITS-1:0] rd_ctr;
   logic                wr_en;
   logic                wr_init;

   assign opc    = bus.i_instr[6:0];
   assign f3     = bus.i_instr[14:12];
   assign fire   = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
   assign seq_pc = bus.i_pc + XLEN'(4);

   always_comb begin
      is_br  = 1'b0;
      is_jmp = 1'b0;
      tgt    = bus.i_pc + bus.i_imm;
      unique case (1'b1)
         (opc == OPC_BRANCH): is_br = is_cond_f3(f3);
         (opc == OPC_JAL):    is_jmp = 1'b1;
         (opc == OPC_JALR): begin
            is_jmp = 1'b1;
            tgt = (bus.i_rs1_val + bus.i_imm) & ~XLEN'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      case (f3)
         F3_BEQ:  cond = bus.i_rs1_val == bus.i_rs2_val;
         F3_BNE:  cond = bus.i_rs1_val != bus.i_rs2_val;
         F3_BLT:  cond = $signed(bus.i_rs1_val) < $signed(bus.i_rs2_val);
         F3_BGE:  cond = $signed(bus.i_rs1_val) >= $signed(bus.i_rs2_val);
         F3_BLTU: cond = bus.i_rs1_val < bus.i_rs2_val;
         F3_BGEU: cond = bus.i_rs1_val >= bus.i_rs2_val;
         default: cond = 1'b0;
      endcase
   end

   assign res_br  = fire & is_br;
   assign res_jmp = fire & is_jmp;
   assign taken   = is_jmp | cond;

   // A jump only escapes redirection when the carried prediction matches.
   always_comb begin
      mp    = 1'b0;
      rd_pc = '0;
      if (res_br) begin
         mp = (bus.i_pred_taken != cond) |
              (cond & bus.i_pred_taken & (bus.i_pred_target != tgt));
         rd_pc = cond ? tgt : seq_pc;
      end else if (res_jmp) begin
         mp    = ~(bus.i_pred_taken & (bus.i_pred_target == tgt));
         rd_pc = tgt;
      end
   end

   assign bus.o_redirect_valid    = mp;
   assign bus.o_mispred           = mp;
   assign bus.o_redirect_pc       = mp ? rd_pc : '0;
   assign bus.o_btb_update        = (res_br | res_jmp) & taken;
   assign bus.o_btb_update_pc     = bus.i_pc;
   assign bus.o_btb_update_target = tgt;

   assign rd_idx  = bus.i_if_pc[IDX_W+1:2];
   assign wr_init = (state == ST_INIT);
   assign wr_idx  = wr_init ? init_idx : bus.i_pc[IDX_W+1:2];
   assign wr_en   = ~i_reset & (wr_init | res_br);

   bht_table #(
      .ENTRIES  (BHT_ENTRIES),
      .CTR_BITS (CTR_BITS),
      .IDX_W    (IDX_W)
   ) u_bht (
      .clk      (i_clk),
      .rd_addr  (rd_idx),
      .rd_data  (rd_ctr),
      .wr_en    (wr_en),
      .wr_init  (wr_init),
      .wr_taken (cond),
      .wr_addr  (wr_idx),
      .init_val (CTR_WNT)
   );

   assign bus.o_if_pred_taken = ~busy & rd_ctr[CTR_BITS-1];
   assign bus.o_busy          = busy;
   assign bus.o_perf_branches = perf_br;
   assign bus.o_perf_mispreds = perf_mp;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_INIT;
         init_idx <= '0;
         busy     <= 1'b1;
         perf_br  <= '0;
         perf_mp  <= '0;
      end else begin
         unique case (state)
            ST_INIT: begin
               init_idx <= init_idx + 1'b1;
               if (&init_idx) begin
                  state <= ST_RUN;
                  busy  <= 1'b0;
               end
            end
            ST_RUN: ;
            default: state <= ST_INIT;
         endcase
         if (bus.i_perf_clear) begin
            perf_br <= '0;
            perf_mp <= '0;
         end else begin
            if (res_br && perf_br != '1) perf_br <= perf_br + 1'b1;
            if (mp && perf_mp != '1) perf_mp <= perf_mp + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_branch_unit.sv
// Scoreboard bench for id_branch_unit against a behavioural model.
module tb_id_branch_unit;

   localparam int PMAX = 15;
   localparam int NENT = 64;

   typedef struct {
      logic        res;
      logic        rv;
      logic [31:0] rpc;
      logic        mp;
      logic        bu;
      logic [31:0] bpc;
      logic [31:0] btg;
      logic        ift;
      logic        busy;
      int          pb;
      int          pm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   id_branch_unit_if #(.XLEN(32), .PERF_W(4)) bus ();

   id_branch_unit #(.PERF_W(4)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   int ctr [NENT];
   int busy_left;
   int pb;
   int pm;

   task automatic chk(input string n,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("redirect_valid", 32'(bus.o_redirect_valid), 32'(e.rv));
         chk("mispred", 32'(bus.o_mispred), 32'(e.mp));
         if (e.rv || !e.res)
            chk("redirect_pc", bus.o_redirect_pc, e.rpc);
         chk("btb_update", 32'(bus.o_btb_update), 32'(e.bu));
         if (e.bu) begin
            chk("btb_pc", bus.o_btb_update_pc, e.bpc);
            chk("btb_target", bus.o_btb_update_target, e.btg);
         end
         chk("if_pred", 32'(bus.o_if_pred_taken), 32'(e.ift));
         chk("busy", 32'(bus.o_busy), 32'(e.busy));
         chk("perf_br", 32'(bus.o_perf_branches), 32'(e.pb));
         chk("perf_mp", 32'(bus.o_perf_mispreds), 32'(e.pm));
      end
   end

   function automatic int idx(input logic [31:0] p);
      return int'((p >> 2) % NENT);
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] o,
                                      input logic [2:0] f);
      return {17'h0, f, 5'h0, o};
   endfunction

   task automatic model_reset();
      busy_left = NENT;
      pb = 0;
      pm = 0;
   endtask

   task automatic drive(input logic v, st, fl,
                        input logic [31:0] pc, ins, imm, a, b,
                        input logic pt,
                        input logic [31:0] ptg, ifpc,
                        input logic clr);
      exp_t e;
      logic [6:0] o;
      logic [2:0] f;
      logic isbr, isj, tk;
      logic [31:0] tg;
      bus.i_valid = v;
      bus.i_stall = st;
      bus.i_flush = fl;
      bus.i_pc = pc;
      bus.i_instr = ins;
      bus.i_imm = imm;
      bus.i_rs1_val = a;
      bus.i_rs2_val = b;
      bus.i_pred_taken = pt;
      bus.i_pred_target = ptg;
      bus.i_if_pc = ifpc;
      bus.i_perf_clear = clr;
      o = ins[6:0];
      f = ins[14:12];
      isbr = (o == 7'h63) && (f != 3'd2) && (f != 3'd3);
      isj = (o == 7'h6F) || (o == 7'h67);
      case (f)
         3'd0: tk = (a == b);
         3'd1: tk = (a != b);
         3'd4: tk = ($signed(a) < $signed(b));
         3'd5: tk = ($signed(a) >= $signed(b));
         3'd6: tk = (a < b);
         default: tk = (a >= b);
      endcase
      if (isj) tk = 1'b1;
      tg = (o == 7'h67) ? ((a + imm) & ~32'h1) : (pc + imm);
      e.res = v && !st && !fl && (isbr || isj);
      e.mp = 1'b0;
      e.rpc = 32'h0;
      if (e.res && isbr) begin
         e.mp = (pt != tk) || (tk && ptg != tg);
         e.rpc = tk ? tg : pc + 32'd4;
      end else if (e.res) begin
         e.mp = !(pt && ptg == tg);
         e.rpc = tg;
      end
      e.rv = e.mp;
      e.bu = e.res && tk;
      e.bpc = pc;
      e.btg = tg;
      e.busy = (busy_left > 0);
      e.ift = !e.busy && (ctr[idx(ifpc)] >= 2);
      e.pb = pb;
      e.pm = pm;
      q.push_back(e);
      if (clr) begin
         pb = 0;
         pm = 0;
      end else begin
         if (e.res && isbr) pb = (pb < PMAX) ? pb + 1 : PMAX;
         if (e.mp) pm = (pm < PMAX) ? pm + 1 : PMAX;
      end
      if (busy_left > 0) begin
         ctr[NENT - busy_left] = 1;
         busy_left--;
      end else if (e.res && isbr) begin
         if (tk) ctr[idx(pc)] = (ctr[idx(pc)] < 3) ? ctr[idx(pc)] + 1 : 3;
         else ctr[idx(pc)] = (ctr[idx(pc)] > 0) ? ctr[idx(pc)] - 1 : 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] ifpc);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ifpc, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   localparam logic [6:0] OPS [5] =
      '{7'h63, 7'h6F, 7'h67, 7'h13, 7'h63};

   initial begin
      logic [31:0] beq, bne, blt, jalr, jal;
      beq  = mk(7'h63, 3'd0);
      bne  = mk(7'h63, 3'd1);
      blt  = mk(7'h63, 3'd4);
      jalr = mk(7'h67, 3'd0);
      jal  = mk(7'h6F, 3'd0);
      for (int i = 0; i < NENT; i++) ctr[i] = 0;
      bus.i_valid = 0; bus.i_stall = 0; bus.i_flush = 0;
      bus.i_pc = 0; bus.i_instr = 0; bus.i_imm = 0;
      bus.i_rs1_val = 0; bus.i_rs2_val = 0;
      bus.i_pred_taken = 0; bus.i_pred_target = 0;
      bus.i_if_pc = 0; bus.i_perf_clear = 0;
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < NENT + 4; i++)
         idle($urandom & 32'h3FC);

      drive(1, 0, 0, 32'h100, beq, 32'h20, 5, 5, 0, 0, 0, 0);
      drive(1, 0, 0, 32'h200, bne, 32'h40, 7, 7,
            1, 32'h240, 0, 0);
      drive(1, 1, 0, 32'h200, bne, 32'h40, 7, 7,
            1, 32'h240, 0, 0);
      drive(1, 0, 0, 32'h300, jalr, 32'h10, 32'h1001, 0,
            1, 32'h1010, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 32'h40, blt, 32'h80, 32'hFFFF_FFFF, 1,
               0, 0, 32'h40, 0);
         idle(32'h40);
      end
      drive(1, 0, 0, 32'h40, blt, 32'h80, 1, 1, 1, 32'hC0, 32'h40, 0);
      idle(32'h40);
      drive(1, 0, 1, 32'h40, blt, 32'h80, 1, 1, 1, 32'hC0, 32'h40, 0);
      idle(32'h40);

      do_reset();
      for (int i = 0; i < 20; i++)
         drive(1, 0, 0, 32'h500, jal, 32'h8, 0, 0, 0, 0, 32'h40, 0);
      drive(1, 0, 0, 32'h500, jal, 32'h8, 0, 0, 0, 0, 32'h40, 1);
      idle(32'h40);
      while (busy_left > 0) idle($urandom & 32'h3FC);

      for (int i = 0; i < 800; i++) begin
         logic [6:0] o;
         logic [2:0] f;
         logic [31:0] pc, imm, a, b, tg, ptg, ifpc;
         o = OPS[$urandom_range(0, 4)];
         f = 3'($urandom);
         pc = $urandom & 32'h3FC;
         imm = 32'($urandom_range(0, 2047)) - 32'd1024;
         a = $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom;
         b = $urandom_range(0, 2) == 0 ? a : $urandom;
         if ($urandom_range(0, 1) == 0) b = a + 32'($urandom_range(0, 2)) - 1;
         tg = (o == 7'h67) ? ((a + imm) & ~32'h1) : (pc + imm);
         ptg = $urandom_range(0, 2) != 0 ? tg : $urandom;
         ifpc = $urandom_range(0, 2) == 0 ? pc : ($urandom & 32'h3FC);
         drive($urandom_range(0, 5) != 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0,
               pc, mk(o, f), imm, a, b,
               1'($urandom), ptg, ifpc,
               $urandom_range(0, 40) == 0);
      end

      repeat (2) @(posedge clk);
      chk("queue_drain", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_branch_unit.md
ID_BRANCH_UNIT -- requirements
Module: id_branch_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter BHT_ENTRIES, default 64, counter-table depth, power of two, >=2.
REQ-003 Parameter CTR_BITS, default 2, saturating-counter width, >=1.
REQ-004 Parameter PERF_W, default 32, performance-counter width.
REQ-005 One clock; reset is synchronous and active-high: i_clk input 1 clock; i_reset input 1 sync active-high reset.
REQ-006 i_stall in 1 ID stalled; i_flush in 1 ID instruction killed; i_valid in 1 decoded instruction valid.
REQ-007 i_pc in XLEN instruction PC; i_instr in 32 instruction word; i_imm in XLEN decoded immediate.
REQ-008 i_rs1_val, i_rs2_val in XLEN already-forwarded operands.
REQ-009 i_pred_taken in 1, i_pred_target in XLEN: IF prediction carried with instruction.
REQ-010 i_if_pc in XLEN IF lookup PC; o_if_pred_taken out 1 counter-based direction prediction.
REQ-011 o_redirect_valid out 1, o_redirect_pc out XLEN: fetch redirect.
REQ-012 o_mispred out 1 misprediction flag; o_btb_update out 1, o_btb_update_pc out XLEN, o_btb_update_target out XLEN.
REQ-013 i_perf_clear in 1; o_perf_branches, o_perf_mispreds out PERF_W; o_busy out 1 table initialising.

Function
REQ-014 "Resolve" = i_valid & !i_stall & !i_flush & instruction is BRANCH (opcode 1100011, funct3 000/001/100/101/110/111), JAL (1101111) or JALR (1100111); funct3 010/011 branches never resolve.
REQ-015 Conditions: BEQ/BNE equality, BLT/BGE signed, BLTU/BGEU unsigned; target = i_pc+i_imm (branch, JAL), (i_rs1_val+i_imm)&~1 (JALR), modulo 2^XLEN.
REQ-016 Branch mispredict: i_pred_taken != actual, or both taken and i_pred_target != target; redirect to target if actually taken, else i_pc+4.
REQ-017 Jump: redirect to target unless i_pred_taken and i_pred_target == target; that case counts as mispredict.
REQ-018 o_redirect_valid, o_redirect_pc, o_mispred combinational, same cycle as resolve; all zero when not resolving.
REQ-019 o_btb_update = resolve & (actual taken | jump); update_pc = i_pc, update_target = target.
REQ-020 Table index = pc[log2(BHT_ENTRIES)+1:2]; o_if_pred_taken = MSB of counter[i_if_pc index], combinational; 0 while o_busy.
REQ-021 On resolved conditional branch in RUN: counter increments if taken, decrements if not, saturating at 2^CTR_BITS-1 and 0; written at next edge.
REQ-022 Same-cycle read and write of one index: read returns pre-update value (no bypass).
REQ-023 FSM INIT->RUN: INIT writes weakly-not-taken (2^(CTR_BITS-1)-1) to index 0..BHT_ENTRIES-1, one per cycle; enters RUN after last write; o_busy=1 exactly in INIT.
REQ-024 During INIT, resolution, redirects and perf counters function normally; counter updates dropped.
REQ-025 o_perf_branches +1 per resolved conditional branch; o_perf_mispreds +1 per asserted o_mispred; both saturate at 2^PERF_W-1.
REQ-026 i_perf_clear zeroes both perf counters next edge, overriding a same-cycle increment.

Reset
REQ-027 i_reset: FSM to INIT, init index 0, perf counters 0; reset during INIT or RUN restarts the full walk.
REQ-028 Counter-table contents not reset directly; valid only via INIT walk.

Structure
REQ-029 Shared package holds opcode constants, branch funct3 encodings, FSM state enum.
REQ-030 One sub-module bht_table: BHT_ENTRIES x CTR_BITS array, one async read, one sync write port.

Verification
REQ-031 Reset, defaults: o_busy=1 for 64 cycles then 0; o_if_pred_taken=0 throughout; counters at 1.
REQ-032 BEQ pc=0x100, imm=0x20, rs1=rs2=5, pred 0 -> redirect 0x120, mispred=1, btb_update=1, perf_mispreds=1.
REQ-033 BNE pc=0x200, equal operands, pred 1 target 0x240 -> redirect 0x204, mispred=1; same instruction with i_stall=1 -> no redirect, no update.
REQ-034 JALR rs1=0x1001, imm=0x10, pred 1 target 0x1010 -> no redirect, no mispred, btb_update target 0x1010.
REQ-035 Three taken BLT at pc 0x40 -> counter 1->2->3->3, o_if_pred_taken(0x40)=1 after first; one not-taken -> 2, still 1.
REQ-036 PERF_W=4: 20 mispredicts -> o_perf_mispreds holds 15; i_perf_clear with concurrent mispredict -> 0.
